// File: rtl/sobel_pkg.sv
// sobel_pkg: definitions shared by the Sobel window address scheduler.
//   - sobel_state_e   : sequencer states
//   - SOBEL_*         : default address width, row stride, anchor range
//   - SOBEL_TAP_COUNT : rows read per 4-row window column
package sobel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRIME = 3'd1,
    ST_TAP0  = 3'd2,
    ST_TAP1  = 3'd3,
    ST_TAP2  = 3'd4,
    ST_TAP3  = 3'd5,
    ST_DONE  = 3'd6
  } sobel_state_e;

  localparam int SOBEL_ADDR_W     = 20;
  localparam int SOBEL_ROW_STRIDE = 256;
  localparam int SOBEL_START_ADDR = 768;
  localparam int SOBEL_END_ADDR   = 65535;
  localparam int SOBEL_TAP_COUNT  = 4;
  localparam int SOBEL_TAP_W      = $clog2(SOBEL_TAP_COUNT);

endpackage

// File: rtl/sobel_anchor_counter.sv
// sobel_anchor_counter: holds the window-anchor address and steps it.
// Build option: SOBEL_ROW_SKIP_EN -- when defined, an anchor in the last
// column (anchor[7:0] == 255) jumps by ROW_STRIDE+1 so the next window
// starts one row further down; otherwise the anchor always steps by +1.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset, anchor <= START_ADDR
//   load   in   reload START_ADDR (frame start)
//   step   in   advance the anchor by one window position
//   anchor out  current anchor address
//   at_end out  anchor equals END_ADDR
module sobel_anchor_counter
  import sobel_pkg::*;
#(
  parameter int ADDR_W     = SOBEL_ADDR_W,
  parameter int ROW_STRIDE = SOBEL_ROW_STRIDE,
  parameter int START_ADDR = SOBEL_START_ADDR,
  parameter int END_ADDR   = SOBEL_END_ADDR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  output logic [ADDR_W-1:0] anchor,
  output logic              at_end
);

  logic [ADDR_W-1:0] anchor_q;
  logic [ADDR_W-1:0] anchor_d;
  logic [ADDR_W-1:0] step_amt;

  always_comb begin
`ifdef SOBEL_ROW_SKIP_EN
    step_amt = (anchor_q[7:0] == 8'hFF) ? ADDR_W'(ROW_STRIDE + 1) : ADDR_W'(1);
`else
    step_amt = ADDR_W'(1);
`endif
    anchor_d = anchor_q;
    if (load) begin
      anchor_d = ADDR_W'(START_ADDR);
    end else if (step) begin
      // Wraps modulo 2^ADDR_W by construction.
      anchor_d = anchor_q + step_amt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      anchor_q <= ADDR_W'(START_ADDR);
    end else begin
      anchor_q <= anchor_d;
    end
  end

  assign anchor = anchor_q;
  assign at_end = (anchor_q == ADDR_W'(END_ADDR));

endmodule

// File: rtl/sobel_addr_scheduler.sv
// sobel_addr_scheduler: issues the SRAM read addresses for a 4-row Sobel
// window sweep. Each anchor produces four reads (anchor, anchor-1 row,
// anchor-2 rows, anchor-3 rows); one extra PRIME read at frame start covers
// the SRAM read latency of the first window.
// Build option: SOBEL_ROW_SKIP_EN (end-of-row anchor step, see
// sobel_anchor_counter).
// Ports:
//   clk       in   system clock
//   reset     in   synchronous active-high reset
//   startEn   in   start pulse, honoured only in IDLE
//   stall     in   consumer not ready, freezes the sequencer
//   read_addr out  registered SRAM read address
//   addrValid out  read_addr was issued on the last edge
//   colPos    out  anchor column (anchor[7:0])
//   rowTap    out  row offset of read_addr (0..3)
//   busy      out  sequencer not in IDLE
//   done      out  one-cycle frame-complete pulse
module sobel_addr_scheduler
  import sobel_pkg::*;
#(
  parameter int ADDR_W     = SOBEL_ADDR_W,
  parameter int ROW_STRIDE = SOBEL_ROW_STRIDE,
  parameter int START_ADDR = SOBEL_START_ADDR,
  parameter int END_ADDR   = SOBEL_END_ADDR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startEn,
  input  logic                   stall,
  output logic [ADDR_W-1:0]      read_addr,
  output logic                   addrValid,
  output logic [7:0]             colPos,
  output logic [SOBEL_TAP_W-1:0] rowTap,
  output logic                   busy,
  output logic                   done
);

  sobel_state_e           state_q;
  logic [ADDR_W-1:0]      read_addr_q;
  logic                   addr_valid_q;
  logic [SOBEL_TAP_W-1:0] row_tap_q;
  logic                   done_q;

  logic [ADDR_W-1:0]      anchor;
  logic                   at_end;
  logic                   anchor_load;
  logic                   anchor_step;

  // Anchor moves only on the TAP3 issue edge, so all four taps of a
  // window share one anchor value.
  assign anchor_load = (state_q == ST_IDLE) && startEn;
  assign anchor_step = (state_q == ST_TAP3) && !stall;

  sobel_anchor_counter #(
    .ADDR_W    (ADDR_W),
    .ROW_STRIDE(ROW_STRIDE),
    .START_ADDR(START_ADDR),
    .END_ADDR  (END_ADDR)
  ) u_anchor (
    .clk   (clk),
    .reset (reset),
    .load  (anchor_load),
    .step  (anchor_step),
    .anchor(anchor),
    .at_end(at_end)
  );

  // Candidate address for every row tap; subtraction wraps modulo 2^ADDR_W.
  logic [ADDR_W-1:0] tap_addr [SOBEL_TAP_COUNT];

  generate
    for (genvar gi = 0; gi < SOBEL_TAP_COUNT; gi++) begin : g_tap
      assign tap_addr[gi] = anchor - ADDR_W'(gi * ROW_STRIDE);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      read_addr_q  <= '0;
      addr_valid_q <= 1'b0;
      row_tap_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      addr_valid_q <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (startEn) begin
            state_q <= ST_PRIME;
          end
        end
        ST_PRIME: begin
          if (!stall) begin
            read_addr_q  <= tap_addr[0];
            row_tap_q    <= 2'd0;
            addr_valid_q <= 1'b1;
            state_q      <= ST_TAP0;
          end
        end
        ST_TAP0: begin
          if (!stall) begin
            read_addr_q  <= tap_addr[0];
            row_tap_q    <= 2'd0;
            addr_valid_q <= 1'b1;
            state_q      <= ST_TAP1;
          end
        end
        ST_TAP1: begin
          if (!stall) begin
            read_addr_q  <= tap_addr[1];
            row_tap_q    <= 2'd1;
            addr_valid_q <= 1'b1;
            state_q      <= ST_TAP2;
          end
        end
        ST_TAP2: begin
          if (!stall) begin
            read_addr_q  <= tap_addr[2];
            row_tap_q    <= 2'd2;
            addr_valid_q <= 1'b1;
            state_q      <= ST_TAP3;
          end
        end
        ST_TAP3: begin
          if (!stall) begin
            read_addr_q  <= tap_addr[3];
            row_tap_q    <= 2'd3;
            addr_valid_q <= 1'b1;
            // End compare uses the anchor before it steps this edge.
            if (at_end) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_TAP0;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign read_addr = read_addr_q;
  assign addrValid = addr_valid_q;
  assign rowTap    = row_tap_q;
  assign done      = done_q;
  assign busy      = (state_q != ST_IDLE);
  assign colPos    = anchor[7:0];

endmodule

// File: tb/tb_sobel_addr_scheduler.sv
module tb_sobel_addr_scheduler;

  localparam int AW     = 20;
  localparam int STRIDE = 256;
  localparam int NI     = 3;
  localparam int MAXQ   = 2200;
  localparam int NVEC   = 13;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic startEn;
  logic stall;

  logic [AW-1:0] ra   [NI];
  logic          av   [NI];
  logic [7:0]    col  [NI];
  logic [1:0]    tap  [NI];
  logic          busy [NI];
  logic          done [NI];

  int checks   = 0;
  int failures = 0;

  // Instance 0: default geometry, short frame reaching past row 3 column 255.
  // Instance 1: tiny frame (anchors 768..770).
  // Instance 2: START_ADDR=0 to exercise address underflow.
  int p_start [NI] = '{768, 768, 0};
  int p_end   [NI] = '{1290, 770, 2};

  sobel_addr_scheduler #(.ADDR_W(AW), .ROW_STRIDE(STRIDE), .START_ADDR(768), .END_ADDR(1290)) u_a (
    .clk(clk), .reset(reset), .startEn(startEn), .stall(stall),
    .read_addr(ra[0]), .addrValid(av[0]), .colPos(col[0]), .rowTap(tap[0]),
    .busy(busy[0]), .done(done[0]));

  sobel_addr_scheduler #(.ADDR_W(AW), .ROW_STRIDE(STRIDE), .START_ADDR(768), .END_ADDR(770)) u_b (
    .clk(clk), .reset(reset), .startEn(startEn), .stall(stall),
    .read_addr(ra[1]), .addrValid(av[1]), .colPos(col[1]), .rowTap(tap[1]),
    .busy(busy[1]), .done(done[1]));

  sobel_addr_scheduler #(.ADDR_W(AW), .ROW_STRIDE(STRIDE), .START_ADDR(0), .END_ADDR(2)) u_c (
    .clk(clk), .reset(reset), .startEn(startEn), .stall(stall),
    .read_addr(ra[2]), .addrValid(av[2]), .colPos(col[2]), .rowTap(tap[2]),
    .busy(busy[2]), .done(done[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: expected address list per frame ----
  int  eq_addr [NI][MAXQ];
  int  eq_tap  [NI][MAXQ];
  int  head [NI];
  int  tail [NI];
  bit  in_frame  [NI];
  bit  pend_idle [NI];
  int  issued    [NI];
  int  done_cnt  [NI];
  bit  done_prev [NI];
  bit  stall_at_edge;

  function automatic int next_anchor(input int a);
`ifdef SOBEL_ROW_SKIP_EN
    if ((a % 256) == 255) return (a + STRIDE + 1) % (1 << AW);
`endif
    return (a + 1) % (1 << AW);
  endfunction

  task automatic build(input int k);
    int a;
    int n;
    int v;
    a = p_start[k];
    n = 0;
    eq_addr[k][n] = a; eq_tap[k][n] = 0; n++;
    while (n + 4 <= MAXQ) begin
      for (int t = 0; t < 4; t++) begin
        v = a - t * STRIDE;
        if (v < 0) v += (1 << AW);
        eq_addr[k][n] = v;
        eq_tap[k][n]  = t;
        n++;
      end
      if (a == p_end[k]) break;
      a = next_anchor(a);
    end
    head[k] = 0;
    tail[k] = n;
  endtask

  // Frame bookkeeping on the active edge (inputs are stable here).
  initial begin
    forever begin
      @(posedge clk);
      stall_at_edge = stall;
      for (int k = 0; k < NI; k++) begin
        if (reset) begin
          in_frame[k] = 0; pend_idle[k] = 0; head[k] = 0; tail[k] = 0;
        end else if (pend_idle[k]) begin
          // DONE -> IDLE edge: a start here is not taken.
          in_frame[k] = 0; pend_idle[k] = 0;
        end else if (!in_frame[k] && startEn) begin
          build(k);
          in_frame[k] = 1; issued[k] = 0; done_cnt[k] = 0;
        end
      end
    end
  end

  logic [AW-1:0] cap_addr;
  bit            cap_ok = 0;
  bit            last_255_t3 = 0;
  logic [AW-1:0] c_addr [5];
  int            c_cnt = 0;

  // Scoreboard sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
        if (stall_at_edge) chk($sformatf("u%0d_stall_novalid", k), 32'(av[k]), 32'd0);
        if (av[k] === 1'b1) begin
          if (head[k] < tail[k]) begin
            chk($sformatf("u%0d_addr[%0d]", k, head[k]), 32'(ra[k]), 32'(eq_addr[k][head[k]]));
            chk($sformatf("u%0d_tap[%0d]", k, head[k]), 32'(tap[k]), 32'(eq_tap[k][head[k]]));
            head[k]++;
          end else begin
            chk($sformatf("u%0d_extra_addr", k), 32'(ra[k]), 32'hFFFF_FFFF);
          end
          issued[k]++;
        end
        if (done_prev[k]) chk($sformatf("u%0d_busy_after_done", k), 32'(busy[k]), 32'd0);
        if (done[k] === 1'b1) begin
          done_cnt[k]++;
          chk($sformatf("u%0d_done_in_frame", k), 32'(in_frame[k]), 32'd1);
          chk($sformatf("u%0d_done_all_issued", k), 32'(tail[k] - head[k]), 32'd0);
          pend_idle[k] = 1;
        end
        done_prev[k] = (done[k] === 1'b1);
      end
      if (av[0] === 1'b1) begin
        if (last_255_t3 && !cap_ok) begin
          cap_addr = ra[0];
          cap_ok   = 1;
        end
        last_255_t3 = (ra[0] == AW'(255)) && (tap[0] == 2'd3);
      end
      if (av[2] === 1'b1 && c_cnt < 5) begin
        c_addr[c_cnt] = ra[2];
        c_cnt++;
      end
    end
  end

  // ---------------- directed table ----------------
  typedef struct {
    logic          st;
    logic          sl;
    logic          av;
    logic [AW-1:0] addr;
    logic [1:0]    tap;
    logic [7:0]    col;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic vec_t mkv(input logic st, input logic sl, input logic v,
                               input int addr, input int t, input int c);
    vec_t r;
    r.st = st; r.sl = sl; r.av = v;
    r.addr = AW'(addr); r.tap = 2'(t); r.col = 8'(c);
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    startEn = 1'b1;
    cyc();
    startEn = 1'b0;
  endtask

  task automatic run_to_idle(input int budget);
    int c;
    c = 0;
    while ((in_frame[0] || in_frame[1] || in_frame[2]) && c < budget) begin
      stall = ($urandom_range(0, 3) == 0);
      cyc();
      c++;
    end
    stall = 1'b0;
    chk("frames_complete", 32'(in_frame[0] | in_frame[1] | in_frame[2]), 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_read_addr"}, 32'(ra[0]), 32'd0);
    chk({tag, "_addrValid"}, 32'(av[0]), 32'd0);
    chk({tag, "_rowTap"}, 32'(tap[0]), 32'd0);
    chk({tag, "_busy"}, 32'(busy[0]), 32'd0);
    chk({tag, "_done"}, 32'(done[0]), 32'd0);
    chk({tag, "_colPos"}, 32'(col[0]), 32'd0);
  endtask

  int c2;
  logic [AW-1:0] cap_exp;

  initial begin
    tbl[0]  = mkv(1, 0, 0,   0, 0, 0);
    tbl[1]  = mkv(0, 0, 1, 768, 0, 0);
    tbl[2]  = mkv(0, 0, 1, 768, 0, 0);
    tbl[3]  = mkv(0, 1, 0, 768, 0, 0);
    tbl[4]  = mkv(1, 1, 0, 768, 0, 0);
    tbl[5]  = mkv(0, 1, 0, 768, 0, 0);
    tbl[6]  = mkv(0, 0, 1, 512, 1, 0);
    tbl[7]  = mkv(0, 0, 1, 256, 2, 0);
    tbl[8]  = mkv(0, 0, 1,   0, 3, 1);
    tbl[9]  = mkv(0, 0, 1, 769, 0, 1);
    tbl[10] = mkv(0, 0, 1, 513, 1, 1);
    tbl[11] = mkv(0, 0, 1, 257, 2, 1);
    tbl[12] = mkv(0, 0, 1,   1, 3, 2);
`ifdef SOBEL_ROW_SKIP_EN
    cap_exp = AW'(1280);
`else
    cap_exp = AW'(1024);
`endif

    reset = 1'b1; startEn = 1'b0; stall = 1'b0;
    cyc();
    cyc();
    chk_reset_vals("rst");
    reset = 1'b0;

    // Start, stall during TAP1, ignored start mid-frame.
    for (int i = 0; i < NVEC; i++) begin
      startEn = tbl[i].st;
      stall   = tbl[i].sl;
      cyc();
      chk($sformatf("vec%0d_valid", i), 32'(av[0]), 32'(tbl[i].av));
      chk($sformatf("vec%0d_addr", i), 32'(ra[0]), 32'(tbl[i].addr));
      chk($sformatf("vec%0d_tap", i), 32'(tap[0]), 32'(tbl[i].tap));
      chk($sformatf("vec%0d_col", i), 32'(col[0]), 32'(tbl[i].col));
      chk($sformatf("vec%0d_busy", i), 32'(busy[0]), 32'd1);
    end
    startEn = 1'b0;
    stall   = 1'b0;

    run_to_idle(20000);
    chk("ub_addr_count", 32'(issued[1]), 32'd13);
    chk("ub_done_count", 32'(done_cnt[1]), 32'd1);
    chk("ua_done_count", 32'(done_cnt[0]), 32'd1);
    chk("row_end_seen", 32'(cap_ok), 32'd1);
    chk("row_end_next_addr", 32'(cap_addr), 32'(cap_exp));
    chk("wrap_cnt", 32'(c_cnt), 32'd5);
    chk("wrap_tap1", 32'(c_addr[2]), 32'h000F_FF00);
    chk("wrap_tap2", 32'(c_addr[3]), 32'h000F_FE00);
    chk("wrap_tap3", 32'(c_addr[4]), 32'h000F_FD00);

    // Reset in TAP2 mid-frame, then restart.
    pulse_start();
    c2 = 0;
    while (!(av[0] === 1'b1 && tap[0] == 2'd1) && c2 < 50) begin
      cyc();
      c2++;
    end
    chk("reach_tap2", 32'(av[0] === 1'b1 && tap[0] == 2'd1), 32'd1);
    reset   = 1'b1;
    startEn = 1'b1;
    stall   = 1'b1;
    cyc();
    reset   = 1'b0;
    startEn = 1'b0;
    stall   = 1'b0;
    chk_reset_vals("midrst");
    pulse_start();
    cyc();
    chk("restart_addr", 32'(ra[0]), 32'd768);
    chk("restart_valid", 32'(av[0]), 32'd1);
    chk("restart_tap", 32'(tap[0]), 32'd0);
    run_to_idle(20000);
    chk("ua_done_count2", 32'(done_cnt[0]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_addr_scheduler.md
SOBEL_ADDR_SCHEDULER -- requirements
Module: sobel_addr_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter ADDR_W, default 20: SRAM word-address width.
REQ-003 Parameter ROW_STRIDE, default 256: words per image row.
REQ-004 Parameter START_ADDR, default 768: first window-anchor address (row 3, column 0).
REQ-005 Parameter END_ADDR, default 65535: last anchor address to be scheduled.
REQ-006 clk  in  1  system clock; all state updates on the rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 startEn  in  1  single-cycle start pulse, sampled only in IDLE.
REQ-009 stall  in  1  consumer not ready; freezes the sequencer.
REQ-010 read_addr  out  ADDR_W  registered SRAM read address.
REQ-011 addrValid  out  1  read_addr was issued on this edge.
REQ-012 colPos  out  8  anchor column, equal to anchor[7:0].
REQ-013 rowTap  out  2  row offset of the current read_addr (0 to 3).
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 done  out  1  one-cycle pulse when the frame is complete.

Function
REQ-016 The FSM SHALL have the states IDLE, PRIME, TAP0, TAP1, TAP2, TAP3 and DONE.
REQ-017 IDLE with startEn=1 SHALL go to PRIME, load anchor<=START_ADDR, and issue no address on that edge.
REQ-018 On each edge in PRIME/TAP0..TAP3 with stall=0, the block SHALL register read_addr, set addrValid=1, and advance the state.
REQ-019 The issued address per state SHALL be:
- PRIME: anchor (tap 0), next state TAP0.
- TAP0: anchor, next TAP1.
- TAP1: anchor-ROW_STRIDE, next TAP2.
- TAP2: anchor-2*ROW_STRIDE, next TAP3.
- TAP3: anchor-3*ROW_STRIDE, next TAP0.
REQ-020 PRIME SHALL be visited once per frame; it covers the SRAM read latency of the first window.
REQ-021 In TAP3, the anchor SHALL advance per REQ-030; if anchor==END_ADDR, the next state SHALL be DONE instead of TAP0.
REQ-022 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-023 With stall=1, state, anchor and read_addr SHALL hold, and addrValid SHALL be 0.
REQ-024 Address arithmetic SHALL be modulo 2^ADDR_W; underflow wraps and is not flagged.
REQ-025 startEn outside IDLE SHALL be ignored. stall in IDLE or DONE SHALL have no effect.
REQ-026 rowTap SHALL be registered together with read_addr: 0 for PRIME and TAP0, 1/2/3 for TAP1/TAP2/TAP3.

Reset
REQ-027 reset=1 SHALL force IDLE at the next edge, from any state including mid-frame, and SHALL override startEn and stall.
REQ-028 Reset values SHALL be: read_addr=0, addrValid=0, rowTap=0, busy=0, done=0, anchor=START_ADDR (so colPos=START_ADDR[7:0]).

Configuration
REQ-029 Macro SOBEL_ROW_SKIP_EN SHALL select the end-of-row step.
REQ-030 With SOBEL_ROW_SKIP_EN defined, the anchor SHALL step +ROW_STRIDE+1 when colPos==255, else +1. Without it, the anchor SHALL always step +1.

Structure
REQ-031 A shared package sobel_pkg SHALL hold the FSM state enum, the default ADDR_W/ROW_STRIDE/START_ADDR constants and the tap-count constant (4).
REQ-032 The anchor register and its step logic SHALL be one sub-module, sobel_anchor_counter, with inputs load, step, and the end-compare output.

Verification
REQ-033 Reset then startEn pulse -> addresses 768,768,512,256,0,769,513,257,1 on consecutive edges; rowTap 0,0,1,2,3,0,1,2,3; busy=1.
REQ-034 Anchor 1023 at TAP3 -> next TAP0 address is 1280 with SOBEL_ROW_SKIP_EN, 1024 without.
REQ-035 stall held 3 cycles during TAP1 -> read_addr frozen, addrValid=0 for 3 cycles, then the sequence resumes unchanged.
REQ-036 END_ADDR=770 -> 13 valid addresses, done pulses once, busy=0 the next cycle; a startEn pulse during the frame is ignored.
REQ-037 reset asserted in TAP2 mid-frame -> all outputs at reset values next cycle; a fresh startEn restarts at 768.
REQ-038 START_ADDR=0 -> TAP1..TAP3 addresses wrap to 0xFFF00, 0xFFE00 and 0xFFD00 with no error.
